// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_frame_ctrl_pkg;

    localparam int          FFT_FRAME_LEN = 1024;
    localparam logic [23:0] FFT_CFG_FWD   = 24'h000001;
    localparam int          FFT_SAMPLE_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_FEED,
        ST_WAIT_RESULT,
        ST_HANDOFF
    } fft_ctrl_state_t;

endpackage

// File: rtl/fft_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: configures the FFT, gates FRAME_LEN-sample frames with tlast,
// waits for the spectrum and strobes the CNN.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int          FRAME_LEN = FFT_FRAME_LEN,
    parameter logic [23:0] CFG_WORD  = FFT_CFG_FWD,
    parameter int          TIMEOUT   = 8192
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    sample_valid,
    input  logic [FFT_SAMPLE_W-1:0] sample_data,
    output logic                    sample_ready,
    output logic [23:0]             fft_cfg_tdata,
    output logic                    fft_cfg_tvalid,
    input  logic                    fft_cfg_tready,
    output logic [FFT_SAMPLE_W-1:0] fft_data_tdata,
    output logic                    fft_data_tvalid,
    input  logic                    fft_data_tready,
    output logic                    fft_data_tlast,
    input  logic                    spec_done,
    input  logic                    cnn_busy,
    output logic                    cnn_start,
    output logic                    busy,
    output logic [15:0]             frame_count,
    output logic [15:0]             drop_count,
    output logic                    err_timeout
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    fft_ctrl_state_t  state;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  to_cnt;
    logic             in_feed;
    logic             data_hs;

    // Valid/ready: a transfer happens on a rising edge where tvalid and tready are both high;
    // the FFT input channel only ever presents data while in FEED.
    assign in_feed         = (state == ST_FEED);
    assign fft_data_tvalid = in_feed & sample_valid;
    assign sample_ready    = in_feed & fft_data_tready;
    assign fft_data_tdata  = sample_data;
    assign fft_data_tlast  = in_feed & (idx == IDX_LAST);
    assign data_hs         = fft_data_tvalid & fft_data_tready;
    assign fft_cfg_tvalid  = (state == ST_CONFIG);
    assign fft_cfg_tdata   = CFG_WORD;
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            to_cnt      <= '0;
            frame_count <= '0;
            cnn_start   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            cnn_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_CONFIG;
                end
                ST_CONFIG: begin
                    if (fft_cfg_tready) begin
                        state <= ST_FEED;
                        idx   <= '0;
                    end
                end
                ST_FEED: begin
                    if (data_hs) begin
                        idx <= idx + IDX_W'(1);
                        if (fft_data_tlast) begin
                            state  <= ST_WAIT_RESULT;
                            to_cnt <= '0;
                        end
                    end
                end
                ST_WAIT_RESULT: begin
                    // spec_done takes priority over an expiring timeout in the same cycle
                    if (spec_done) begin
                        state <= ST_HANDOFF;
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_HANDOFF: begin
                    if (!cnn_busy) begin
                        cnn_start   <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        state       <= continuous ? ST_CONFIG : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sample_valid & ~sample_ready),
        .clear (1'b0),
        .count (drop_count)
    );

endmodule
